write_buffer_fifo: RTL and testbench

Multi-entry, parametrised write buffer between the data cache's dirty-line eviction path and the AXI write master. It queues full cache lines with word-granular merge on address hit. It forwards buffered data to cache refill reads and drains entries in FIFO order over a valid/ready handshake. It generalises the single-entry buffer to DEPTH entries, adds a head-lock rule so data under transfer is never modified, and adds an arbitration grant input.

---
 rtl/write_buffer_fifo.sv | 141 ++++++++++++++
 tb/tb_write_buffer_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer_fifo.sv
// Multi-entry line write buffer: merges word writes into queued lines, forwards to refill reads, drains in FIFO order.
// Latency: accepted write visible next cycle; head offered one cycle after allocate. Backpressure: wready_o=0 when full and no merge target; head held until axi_ready_i.
module write_buffer_fifo #(
    parameter int DEPTH  = 4,
    parameter int WORDS  = 8,
    parameter int ADDR_W = 32,
    parameter int CW     = $clog2(DEPTH+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wreq_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [32*WORDS-1:0] wdata_i,
    input  logic [WORDS-1:0]    wsel_i,
    output logic                wready_o,
    output logic                whit_o,
    input  logic                rreq_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic                rhit_o,
    output logic [32*WORDS-1:0] rdata_o,
    input  logic                axi_grant_i,
    output logic                axi_wen_o,
    output logic [ADDR_W-1:0]   axi_waddr_o,
    output logic [32*WORDS-1:0] axi_wdata_o,
    input  logic                axi_ready_i,
    output logic [CW-1:0]       count_o,
    output logic                empty_o,
    output logic                full_o
);
    localparam int LW = 32*WORDS;
    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WORDS*4-1);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [LW-1:0]     data_q [DEPTH];
    logic [LW-1:0]     data_d [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              lock_q, lock_d;

    logic [ADDR_W-1:0] waddr_al, raddr_al;
    logic              head_locked;
    logic              merge_hit, read_hit;
    logic [PW-1:0]     merge_idx, ridx;
    logic [LW-1:0]     read_dat, sel_mask;
    logic              do_merge, do_push, do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    // Once offered, the head stays offered until accepted, regardless of grant.
    assign axi_wen_o = !empty_o && (axi_grant_i || lock_q);

    always_comb begin
        waddr_al    = waddr_i & LINE_MASK;
        raddr_al    = raddr_i & LINE_MASK;
        // The head is off-limits for merging from the first cycle it is offered.
        head_locked = lock_q || axi_wen_o;
        merge_hit   = 1'b0;
        merge_idx   = '0;
        read_hit    = 1'b0;
        read_dat    = '0;
        ridx        = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == waddr_al && !(head_locked && PW'(i) == head_q)) begin
                merge_hit = 1'b1;
                merge_idx = PW'(i);
            end
        end
        // Walk oldest to youngest so the last match wins.
        for (int k = 0; k < DEPTH; k++) begin
            ridx = head_q + PW'(k);
            if (valid_q[ridx] && addr_q[ridx] == raddr_al) begin
                read_hit = 1'b1;
                read_dat = data_q[ridx];
            end
        end
    end

    assign whit_o      = merge_hit;
    assign wready_o    = rst && (merge_hit || !full_o);
    assign rhit_o      = read_hit;
    assign rdata_o     = (rreq_i && read_hit) ? read_dat : '0;
    assign axi_waddr_o = empty_o ? '0 : addr_q[head_q];
    assign axi_wdata_o = empty_o ? '0 : data_q[head_q];

    always_comb begin
        do_merge = wreq_i && merge_hit;
        do_push  = wreq_i && !merge_hit && !full_o;
        do_pop   = axi_wen_o && axi_ready_i;
        for (int w = 0; w < WORDS; w++) begin
            sel_mask[w*32 +: 32] = {32{wsel_i[w]}};
        end
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        lock_d  = lock_q;
        if (do_merge) begin
            data_d[merge_idx] = (data_q[merge_idx] & ~sel_mask) | (wdata_i & sel_mask);
        end
        if (do_push) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = waddr_al;
            data_d[tail_q]  = wdata_i;
            tail_d          = tail_q + PW'(1);
        end
        if (do_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
            lock_d          = 1'b0;
        end else if (axi_wen_o) begin
            lock_d = 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            lock_q  <= lock_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_write_buffer_fifo.sv
// Randomized + directed bench for write_buffer_fifo; queue-based reference model with AXI drain scoreboard.
module tb_write_buffer_fifo;
    localparam int DEPTH = 4;
    typedef logic [255:0] line_t;
    typedef struct {
        logic [31:0] a;
        line_t       d;
    } ent_t;

    logic        clk, rst, wreq_i, rreq_i, axi_grant_i, axi_ready_i;
    logic [31:0] waddr_i, raddr_i;
    line_t       wdata_i;
    logic [7:0]  wsel_i;
    logic        wready_o, whit_o, rhit_o, axi_wen_o, empty_o, full_o;
    line_t       rdata_o, axi_wdata_o;
    logic [31:0] axi_waddr_o;
    logic [2:0]  count_o;

    int checks = 0;
    int failures = 0;
    ent_t mq[$];
    ent_t exp_q[$];
    logic lock_m = 1'b0;

    write_buffer_fifo dut (
        .clk(clk), .rst(rst),
        .wreq_i(wreq_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .wsel_i(wsel_i),
        .wready_o(wready_o), .whit_o(whit_o),
        .rreq_i(rreq_i), .raddr_i(raddr_i), .rhit_o(rhit_o), .rdata_o(rdata_o),
        .axi_grant_i(axi_grant_i), .axi_wen_o(axi_wen_o), .axi_waddr_o(axi_waddr_o),
        .axi_wdata_o(axi_wdata_o), .axi_ready_i(axi_ready_i),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic line_t rline();
        line_t l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    // One clock cycle: drive, check combinational outputs against the model, advance the model.
    task automatic cycle(input logic r, input logic wq, input logic [31:0] wa, input line_t wd,
                         input logic [7:0] ws, input logic rq, input logic [31:0] ra,
                         input logic g, input logic rd);
        int n, mi;
        logic off, hit, full, rh;
        logic [31:0] wal, ral;
        line_t rdat;
        ent_t e;
        @(negedge clk);
        rst = r; wreq_i = wq; waddr_i = wa; wdata_i = wd; wsel_i = ws;
        rreq_i = rq; raddr_i = ra; axi_grant_i = g; axi_ready_i = rd;
        #1;
        if (!r) begin
            chk("wready_in_reset", line_t'(wready_o), 0);
            mq.delete();
            lock_m = 1'b0;
        end else begin
            n   = mq.size();
            off = (n > 0) && (g || lock_m);
            wal = wa & ~32'h1F;
            ral = ra & ~32'h1F;
            mi  = -1;
            for (int j = 0; j < n; j++)
                if (mq[j].a == wal && !(j == 0 && off)) mi = j;
            hit  = (mi >= 0);
            full = (n == DEPTH);
            rh   = 1'b0;
            rdat = '0;
            for (int j = 0; j < n; j++)
                if (mq[j].a == ral) begin
                    rh = 1'b1;
                    if (rq) rdat = mq[j].d;
                end
            chk("whit", line_t'(whit_o), line_t'(hit));
            chk("wready", line_t'(wready_o), line_t'(hit || !full));
            chk("rhit", line_t'(rhit_o), line_t'(rh));
            chk("rdata", rdata_o, rdat);
            chk("axi_wen", line_t'(axi_wen_o), line_t'(off));
            chk("axi_waddr", line_t'(axi_waddr_o), (n > 0) ? line_t'(mq[0].a) : '0);
            chk("axi_wdata", axi_wdata_o, (n > 0) ? mq[0].d : '0);
            chk("count", line_t'(count_o), line_t'(n));
            chk("empty", line_t'(empty_o), line_t'(n == 0));
            chk("full", line_t'(full_o), line_t'(full));
            if (wq && hit) begin
                e = mq[mi];
                for (int w = 0; w < 8; w++)
                    if (ws[w]) e.d[w*32 +: 32] = wd[w*32 +: 32];
                mq[mi] = e;
            end
            if (off && rd) begin
                exp_q.push_back(mq[0]);
                void'(mq.pop_front());
                lock_m = 1'b0;
            end else if (off) begin
                lock_m = 1'b1;
            end
            if (wq && !hit && !full) begin
                e.a = wal;
                e.d = wd;
                mq.push_back(e);
            end
        end
    endtask

    task automatic wr(input logic [31:0] a, input line_t d, input logic [7:0] ws, input logic g, input logic rd);
        cycle(1'b1, 1'b1, a, d, ws, 1'b0, 32'h0, g, rd);
    endtask

    task automatic idle(input logic g, input logic rd, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, '0, 8'h00, 1'b0, 32'h0, g, rd);
    endtask

    task automatic rdq(input logic [31:0] a, input logic g, input logic rd);
        cycle(1'b1, 1'b0, 32'h0, '0, 8'h00, 1'b1, a, g, rd);
    endtask

    // Drain monitor: every DUT handshake must match the next line the model popped.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && axi_wen_o && axi_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL drain_unexpected actual_addr=%h required=none", axi_waddr_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("drain_addr", line_t'(axi_waddr_o), line_t'(e.a));
                    chk("drain_data", axi_wdata_o, e.d);
                end
            end
        end
    end

    initial begin
        line_t la, lb, ml;
        logic [31:0] ra_addr;
        rst = 1'b0; wreq_i = 1'b0; waddr_i = '0; wdata_i = '0; wsel_i = '0;
        rreq_i = 1'b0; raddr_i = '0; axi_grant_i = 1'b0; axi_ready_i = 1'b0;

        cycle(1'b0, 1'b0, 32'h0, '0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h100, '0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        rdq(32'h100, 1'b1, 1'b1);

        // Fill to full with grant low, refused fifth write, then in-order drain.
        for (int i = 0; i < 4; i++) wr(32'h100 + 32'(i) * 32'h20, rline(), 8'hFF, 1'b0, 1'b0);
        wr(32'h180, rline(), 8'hFF, 1'b0, 1'b0);
        chk("fill_refused", line_t'(wready_o), 0);
        idle(1'b1, 1'b1, 5);

        // Word merge into a queued line, then forwarded read from an unaligned address.
        wr(32'h200, {8{32'hA5A5A5A5}}, 8'hFF, 1'b0, 1'b0);
        la = rline();
        la[63:32] = 32'hDEADBEEF;
        wr(32'h204, la, 8'b0000_0010, 1'b0, 1'b0);
        rdq(32'h21C, 1'b0, 1'b0);
        ml = {8{32'hA5A5A5A5}};
        ml[63:32] = 32'hDEADBEEF;
        chk("merge_line", rdata_o, ml);
        idle(1'b1, 1'b1, 2);

        // Head lock: rewrite of the offered head allocates; grant drop keeps the offer.
        la = rline();
        lb = rline();
        wr(32'h300, la, 8'hFF, 1'b1, 1'b0);
        wr(32'h300, lb, 8'h01, 1'b1, 1'b0);
        rdq(32'h300, 1'b0, 1'b0);
        chk("lock_read_new", rdata_o, lb);
        chk("lock_axi_old", axi_wdata_o, la);
        idle(1'b0, 1'b0, 2);
        idle(1'b0, 1'b1, 1);
        idle(1'b1, 1'b1, 2);

        // Full with simultaneous pop: push refused, accepted the following cycle.
        for (int i = 0; i < 4; i++) wr(32'h400 + 32'(i) * 32'h20, rline(), 8'hFF, 1'b0, 1'b0);
        wr(32'h480, rline(), 8'hFF, 1'b1, 1'b1);
        wr(32'h480, rline(), 8'hFF, 1'b1, 1'b0);
        idle(1'b1, 1'b0, 1);
        chk("refill_count", line_t'(count_o), 4);
        idle(1'b1, 1'b1, 5);

        // Wrap-around through repeated push/pop pairs.
        for (int i = 0; i < 10; i++) wr(32'h500 + 32'(i) * 32'h20, rline(), 8'hFF, 1'b1, 1'b1);
        idle(1'b1, 1'b1, 2);

        // Reset while the head is offered.
        for (int i = 0; i < 3; i++) wr(32'h600 + 32'(i) * 32'h20, rline(), 8'hFF, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1);
        cycle(1'b0, 1'b0, 32'h0, '0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) rdq(32'h600 + 32'(i) * 32'h20, 1'b1, 1'b1);

        // Randomized traffic over a small line pool to exercise merges and duplicates.
        for (int i = 0; i < 400; i++) begin
            ra_addr = 32'h1000 + 32'($urandom_range(0, 5)) * 32'h20 + 32'($urandom_range(0, 31));
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  32'h1000 + 32'($urandom_range(0, 5)) * 32'h20 + 32'($urandom_range(0, 31)),
                  rline(), 8'($urandom),
                  1'($urandom_range(0, 1)), ra_addr,
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end
        idle(1'b1, 1'b1, 6);
        @(negedge clk);
        #3;
        chk("drain_pending", line_t'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
